wishbone_noc_ni: RTL and testbench

WISHBONE_NOC_NI -- requirements
Module: wishbone_noc_ni

---
 rtl/ni_pkg.sv | 54 +++++
 rtl/wishbone_noc_ni.sv | 157 +++++++++++++++
 tb/tb_wishbone_noc_ni.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ni_pkg.sv
// ni_pkg: shared definitions for the Wishbone-to-NoC network interface.
//   FLIT_W        flit width (2-bit type + 32-bit payload)
//   flit_type_e   flit type codes carried in flit[33:32]
//   HEAD_*        bit positions of the fields inside a head payload
//   TIMEOUT_DATA  read data returned when no response arrives in time
//   ni_state_e    request/response sequencer states
//   pack_head     builds a head payload from its fields
//   pack_flit     joins a type code and a payload into one flit
package ni_pkg;

  localparam int unsigned FLIT_W = 34;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  localparam int unsigned HEAD_DEST_LSB = 28;
  localparam int unsigned HEAD_SRC_LSB  = 24;
  localparam int unsigned HEAD_WE_BIT   = 23;
  localparam int unsigned HEAD_SEL_LSB  = 19;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_HEAD,
    ST_SEND_ADDR,
    ST_SEND_DATA,
    ST_WAIT_RESP,
    ST_DONE
  } ni_state_e;

  function automatic logic [31:0] pack_head(input logic [3:0] dest,
                                            input logic [3:0] src,
                                            input logic       we,
                                            input logic [3:0] sel);
    logic [31:0] h;
    h                     = '0;
    h[HEAD_DEST_LSB +: 4] = dest;
    h[HEAD_SRC_LSB +: 4]  = src;
    h[HEAD_WE_BIT]        = we;
    h[HEAD_SEL_LSB +: 4]  = sel;
    return h;
  endfunction

  function automatic logic [FLIT_W-1:0] pack_flit(input flit_type_e  t,
                                                  input logic [31:0] payload);
    return {t, payload};
  endfunction

endpackage

// File: rtl/wishbone_noc_ni.sv
// wishbone_noc_ni: Wishbone slave that turns each transfer into a NoC request
// packet and returns the single-flit response as the Wishbone read data.
//   clk_i, rst_n        clock, synchronous active-low reset
//   wb_cyc_i/stb_i/we_i Wishbone cycle, strobe, write enable
//   wb_addr_i           address; [31:28] selects the destination node
//   wb_data_i/sel_i     write data and byte select
//   wb_data_o           read data (DEADBEEF on timeout)
//   wb_ack_o/err_o      one-cycle completion / timeout pulses
//   tx_valid_o/flit_o   request flit to the NoC, tx_ready_i accepts it
//   rx_valid_i/flit_i   response flit from the NoC, rx_ready_o accepts it
// Writes go out as HEAD, BODY(addr), TAIL(wdata); reads as HEAD, TAIL(addr).
module wishbone_noc_ni
  import ni_pkg::*;
#(
  parameter logic [3:0]  SRC_ID      = 4'd0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_data_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              tx_valid_o,
  output logic [FLIT_W-1:0] tx_flit_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [FLIT_W-1:0] rx_flit_i,
  output logic              rx_ready_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  ni_state_e        state;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [CNT_W-1:0] cnt;
  // Set once the master abandons the cycle; the packet still drains but
  // the completion pulse is withheld.
  logic             abort_q;
  logic             abort_now;
  logic             resp_hit;
  logic             timed_out;

  always_comb begin
    abort_now = abort_q | ~wb_cyc_i;
    resp_hit  = rx_valid_i && (rx_flit_i[FLIT_W-1 -: 2] == FLIT_SINGLE);
    timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      cnt        <= '0;
      abort_q    <= 1'b0;
      wb_data_o  <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      tx_valid_o <= 1'b0;
      tx_flit_o  <= '0;
      rx_ready_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (state != ST_IDLE && state != ST_DONE && !wb_cyc_i) begin
        abort_q <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            addr_q     <= wb_addr_i;
            data_q     <= wb_data_i;
            we_q       <= wb_we_i;
            sel_q      <= wb_sel_i;
            abort_q    <= 1'b0;
            tx_valid_o <= 1'b1;
            tx_flit_o  <= pack_flit(FLIT_HEAD,
                                    pack_head(wb_addr_i[31:28], SRC_ID,
                                              wb_we_i, wb_sel_i));
            state      <= ST_SEND_HEAD;
          end
        end

        ST_SEND_HEAD: begin
          if (tx_ready_i) begin
            // The address closes a read packet but is a body flit of a write.
            tx_flit_o <= pack_flit(we_q ? FLIT_BODY : FLIT_TAIL, addr_q);
            state     <= ST_SEND_ADDR;
          end
        end

        ST_SEND_ADDR: begin
          if (tx_ready_i) begin
            if (we_q) begin
              tx_flit_o <= pack_flit(FLIT_TAIL, data_q);
              state     <= ST_SEND_DATA;
            end else begin
              tx_valid_o <= 1'b0;
              tx_flit_o  <= '0;
              rx_ready_o <= 1'b1;
              cnt        <= '0;
              state      <= ST_WAIT_RESP;
            end
          end
        end

        ST_SEND_DATA: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            tx_flit_o  <= '0;
            rx_ready_o <= 1'b1;
            cnt        <= '0;
            state      <= ST_WAIT_RESP;
          end
        end

        ST_WAIT_RESP: begin
          // Non-SINGLE flits are accepted (rx_ready_o stays high) and ignored.
          if (resp_hit) begin
            wb_data_o  <= rx_flit_i[31:0];
            wb_ack_o   <= ~abort_now;
            rx_ready_o <= 1'b0;
            state      <= ST_DONE;
          end else if (timed_out) begin
            wb_data_o  <= TIMEOUT_DATA;
            wb_err_o   <= ~abort_now;
            rx_ready_o <= 1'b0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_noc_ni.sv
module tb_wishbone_noc_ni;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_addr_i, wb_data_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_data_o;
  logic        wb_ack_o, wb_err_o;
  logic        tx_valid_o;
  logic [33:0] tx_flit_o;
  logic        tx_ready_i;
  logic        rx_valid_i;
  logic [33:0] rx_flit_i;
  logic        rx_ready_o;

  int checks = 0;
  int errors = 0;

  wishbone_noc_ni #(.SRC_ID(4'd0), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_sel_i(wb_sel_i),
    .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .tx_valid_o(tx_valid_o), .tx_flit_o(tx_flit_o), .tx_ready_i(tx_ready_i),
    .rx_valid_i(rx_valid_i), .rx_flit_i(rx_flit_i), .rx_ready_o(rx_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter and record of every accepted request flit with its edge index.
  int unsigned edge_n = 0;
  logic [33:0] fq[$];
  int unsigned eq[$];
  always @(posedge clk_i) begin
    if (tx_valid_o && tx_ready_i) begin
      fq.push_back(tx_flit_o);
      eq.push_back(edge_n);
    end
    edge_n <= edge_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = addr; wb_data_i = data; wb_sel_i = sel;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid_o); end
    checks++; if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL rst_rx_ready: got %b expected 0", rx_ready_o); end
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", wb_err_o); end
    checks++; if (wb_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 00000000", wb_data_o); end
    checks++; if (tx_flit_o !== 34'h0) begin errors++; $display("FAIL rst_flit: got %h expected 000000000", tx_flit_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    int unsigned n;
    fq.delete(); eq.delete();
    tx_ready_i = 1'b1;
    wb_req(1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF);
    step(); n = edge_n - 1;
    checks++; if (tx_valid_o !== 1'b1 || tx_flit_o !== 34'h1_30F8_0000) begin errors++; $display("FAIL wr_head_out: got v=%b %h expected v=1 130f80000", tx_valid_o, tx_flit_o); end
    step(); step(); step();
    checks++; if (rx_ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin errors++; $display("FAIL wr_wait_state: got rx_ready=%b tx_valid=%b expected 1/0", rx_ready_o, tx_valid_o); end
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_0000_00A5;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin errors++; $display("FAIL wr_ack: got ack=%b err=%b expected 1/0", wb_ack_o, wb_err_o); end
    checks++; if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL wr_rx_ready_done: got %b expected 0", rx_ready_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse: got %b expected 0", wb_ack_o); end
    checks++; if (fq.size() != 3) begin errors++; $display("FAIL wr_flit_count: got %0d expected 3", fq.size()); end
    else begin
      checks++; if (fq[0] !== 34'h1_30F8_0000) begin errors++; $display("FAIL wr_flit0: got %h expected 130f80000", fq[0]); end
      checks++; if (fq[1] !== 34'h0_3000_0010) begin errors++; $display("FAIL wr_flit1: got %h expected 030000010", fq[1]); end
      checks++; if (fq[2] !== 34'h2_1234_5678) begin errors++; $display("FAIL wr_flit2: got %h expected 212345678", fq[2]); end
      checks++; if (eq[0] != n + 1 || eq[2] != n + 3) begin errors++; $display("FAIL wr_flit_timing: got head@+%0d tail@+%0d expected +1 +3", eq[0] - n, eq[2] - n); end
    end
  endtask

  task automatic test_read();
    int unsigned n;
    fq.delete(); eq.delete();
    tx_ready_i = 1'b1;
    wb_req(1'b0, 32'h5000_0004, 32'h0, 4'hF);
    step(); n = edge_n - 1;
    step(); step();
    checks++; if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL rd_rx_ready: got %b expected 1", rx_ready_o); end
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_CAFE_BABE;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1 || wb_data_o !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd_ack_data: got ack=%b data=%h expected 1 cafebabe", wb_ack_o, wb_data_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b0 || wb_data_o !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd_after: got ack=%b data=%h expected 0 cafebabe", wb_ack_o, wb_data_o); end
    checks++; if (fq.size() != 2) begin errors++; $display("FAIL rd_flit_count: got %0d expected 2", fq.size()); end
    else begin
      checks++; if (fq[0] !== 34'h1_5078_0000) begin errors++; $display("FAIL rd_flit0: got %h expected 150780000", fq[0]); end
      checks++; if (fq[1] !== 34'h2_5000_0004) begin errors++; $display("FAIL rd_flit1: got %h expected 250000004", fq[1]); end
      checks++; if (eq[1] != n + 2) begin errors++; $display("FAIL rd_tail_timing: got +%0d expected +2", eq[1] - n); end
    end
  endtask

  task automatic test_tx_stall();
    int unsigned n;
    fq.delete(); eq.delete();
    tx_ready_i = 1'b1;
    wb_req(1'b1, 32'hA000_0100, 32'h0BAD_F00D, 4'h3);
    step(); n = edge_n - 1;
    step();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (tx_valid_o !== 1'b1 || tx_flit_o !== 34'h0_A000_0100) begin errors++; $display("FAIL stall_hold%0d: got v=%b %h expected v=1 0a0000100", i, tx_valid_o, tx_flit_o); end
    end
    checks++; if (fq.size() != 1) begin errors++; $display("FAIL stall_no_advance: got %0d flits expected 1", fq.size()); end
    tx_ready_i = 1'b1;
    step(); step();
    checks++; if (fq.size() != 3) begin errors++; $display("FAIL stall_flit_count: got %0d expected 3", fq.size()); end
    else begin
      checks++; if (fq[2] !== 34'h2_0BAD_F00D || eq[1] != n + 7) begin errors++; $display("FAIL stall_resume: got %h @+%0d expected 20badf00d @+7", fq[2], eq[1] - n); end
    end
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_0000_0001;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL stall_ack: got %b expected 1", wb_ack_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    tx_ready_i = 1'b1;
    wb_req(1'b0, 32'h7000_0000, 32'h0, 4'h1);
    step();
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step(); k++;
      if (wb_err_o === 1'b1 || wb_ack_o === 1'b1) break;
    end
    checks++; if (wb_err_o !== 1'b1 || wb_ack_o !== 1'b0) begin errors++; $display("FAIL to_err: got err=%b ack=%b expected 1/0", wb_err_o, wb_ack_o); end
    checks++; if (k != 18) begin errors++; $display("FAIL to_latency: got %0d cycles expected 18", k); end
    checks++; if (wb_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_data: got %h expected deadbeef", wb_data_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    checks++; if (wb_err_o !== 1'b0 || wb_ack_o !== 1'b0) begin errors++; $display("FAIL to_pulse: got err=%b ack=%b expected 0/0", wb_err_o, wb_ack_o); end
  endtask

  task automatic test_drop_body();
    tx_ready_i = 1'b1;
    wb_req(1'b0, 32'h2000_0008, 32'h0, 4'hF);
    step(); step(); step();
    rx_valid_i = 1'b1; rx_flit_i = 34'h0_FFFF_0000;
    step();
    checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || rx_ready_o !== 1'b1) begin errors++; $display("FAIL drop_body: got ack=%b err=%b rx_ready=%b expected 0/0/1", wb_ack_o, wb_err_o, rx_ready_o); end
    rx_flit_i = 34'h3_1111_2222;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1 || wb_data_o !== 32'h1111_2222) begin errors++; $display("FAIL drop_single: got ack=%b data=%h expected 1 11112222", wb_ack_o, wb_data_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_abort();
    fq.delete(); eq.delete();
    tx_ready_i = 1'b1;
    wb_req(1'b1, 32'h4000_0020, 32'h5555_AAAA, 4'hF);
    step(); step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step(); step();
    checks++; if (fq.size() != 3 || rx_ready_o !== 1'b1) begin errors++; $display("FAIL abort_drain: got %0d flits rx_ready=%b expected 3 1", fq.size(), rx_ready_o); end
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_0000_0077;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0 || rx_ready_o !== 1'b0) begin errors++; $display("FAIL abort_suppress: got ack=%b err=%b rx_ready=%b expected 0/0/0", wb_ack_o, wb_err_o, rx_ready_o); end
    step();
    checks++; if (wb_ack_o !== 1'b0 || tx_valid_o !== 1'b0) begin errors++; $display("FAIL abort_idle: got ack=%b tx_valid=%b expected 0/0", wb_ack_o, tx_valid_o); end
  endtask

  task automatic test_reset_mid_packet();
    fq.delete(); eq.delete();
    tx_ready_i = 1'b0;
    wb_req(1'b1, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF);
    step();
    checks++; if (tx_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_head: got %b expected 1", tx_valid_o); end
    rst_n = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    checks++; if (tx_valid_o !== 1'b0 || tx_flit_o !== 34'h0) begin errors++; $display("FAIL rmid_cleared: got v=%b %h expected v=0 000000000", tx_valid_o, tx_flit_o); end
    rst_n = 1'b1; tx_ready_i = 1'b1;
    step(); step(); step();
    checks++; if (tx_valid_o !== 1'b0 || fq.size() != 0) begin errors++; $display("FAIL rmid_no_resume: got v=%b %0d flits expected v=0 0", tx_valid_o, fq.size()); end
    wb_req(1'b0, 32'h6000_000C, 32'h0, 4'hF);
    step(); step(); step();
    checks++; if (fq.size() != 2 || fq[0] !== 34'h1_6078_0000) begin errors++; $display("FAIL rmid_read_flits: got %0d flits head=%h expected 2 160780000", fq.size(), fq[0]); end
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_1357_9BDF;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1 || wb_data_o !== 32'h1357_9BDF) begin errors++; $display("FAIL rmid_read_ack: got ack=%b data=%h expected 1 13579bdf", wb_ack_o, wb_data_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    tx_ready_i = 1'b1;
    wb_req(1'b0, 32'h1000_0000, 32'h0, 4'hF);
    step(); step(); step();
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_0000_0001;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1 || wb_data_o !== 32'h0000_0001) begin errors++; $display("FAIL b2b_ack1: got ack=%b data=%h expected 1 00000001", wb_ack_o, wb_data_o); end
    wb_addr_i = 32'h8000_0004;
    step();
    checks++; if (tx_valid_o !== 1'b0 || wb_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_done_no_accept: got tx_valid=%b ack=%b expected 0/0", tx_valid_o, wb_ack_o); end
    step();
    checks++; if (tx_valid_o !== 1'b1 || tx_flit_o !== 34'h1_8078_0000) begin errors++; $display("FAIL b2b_accept2: got v=%b %h expected v=1 180780000", tx_valid_o, tx_flit_o); end
    step(); step();
    rx_valid_i = 1'b1; rx_flit_i = 34'h3_0000_0002;
    step(); rx_valid_i = 1'b0;
    checks++; if (wb_ack_o !== 1'b1 || wb_data_o !== 32'h0000_0002) begin errors++; $display("FAIL b2b_ack2: got ack=%b data=%h expected 1 00000002", wb_ack_o, wb_data_o); end
    step(); wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
    tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_flit_i = '0;
    test_reset();
    test_write();
    test_read();
    test_tx_stall();
    test_timeout();
    test_drop_body();
    test_abort();
    test_reset_mid_packet();
    test_back_to_back();
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
